floating_point_spdiv: RTL and testbench

//  Sequential IEEE-754 single-precision divider (y = a / b), the inverse companion of floating_point_spmul.

---
 rtl/fp_sp_pkg.sv | 23 ++
 rtl/fp_mant_div_seq.sv | 69 ++++++
 rtl/floating_point_spdiv.sv | 168 ++++++++++++++++
 tb/tb_floating_point_spdiv.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fp_sp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp_sp_pkg                                                   |
// | Brief   : IEEE-754 single-precision field constants and FSM encodings |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fp_sp_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_UNPACK = 3'd1;
    localparam state_t ST_DIV    = 3'd2;
    localparam state_t ST_ROUND  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
endpackage : fp_sp_pkg
`default_nettype wire

// File: rtl/fp_mant_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp_mant_div_seq                                             |
// | Brief   : Radix-2 restoring mantissa divider, one quotient bit/cycle  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fp_mant_div_seq #(
    parameter int QUO_BITS = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [24:0]         i_dividend,
    input  logic [23:0]         i_divisor,
    output logic                o_done,
    output logic [QUO_BITS-1:0] o_quotient,
    output logic                o_sticky
);
    logic [25:0]         r_rem;
    logic [23:0]         r_divisor;
    logic [QUO_BITS-1:0] r_quo;
    logic [4:0]          r_cnt;
    logic                r_busy;

    logic [25:0] w_rem_src;
    logic [23:0] w_dsr;
    logic [25:0] w_trial;
    logic        w_qbit;
    logic [25:0] w_rem_nxt;

    // The start cycle already produces the MSB quotient bit from the live inputs.
    always_comb begin
        w_rem_src = i_start ? {1'b0, i_dividend} : r_rem;
        w_dsr     = i_start ? i_divisor : r_divisor;
        w_trial   = w_rem_src - {2'b00, w_dsr};
        w_qbit    = ~w_trial[25];
        w_rem_nxt = {(w_qbit ? w_trial[24:0] : w_rem_src[24:0]), 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (i_start) begin
            r_divisor <= i_divisor;
            r_rem     <= w_rem_nxt;
            r_quo     <= {{(QUO_BITS-1){1'b0}}, w_qbit};
            r_cnt     <= 5'(QUO_BITS - 2);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[QUO_BITS-2:0], w_qbit};
            if (r_cnt == 5'd0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    // High during the final iteration; the quotient is complete after this edge.
    assign o_done     = r_busy && (r_cnt == 5'd0);
    assign o_quotient = r_quo;
    assign o_sticky   = (r_rem != 26'd0);
endmodule : fp_mant_div_seq
`default_nettype wire

// File: rtl/floating_point_spdiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : floating_point_spdiv                                        |
// | Brief   : Sequential IEEE-754 single-precision divider, y = a / b     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module floating_point_spdiv
    import fp_sp_pkg::*;
#(
    parameter int QUO_BITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        u_flow,
    output logic        o_flow,
    output logic        div_by_zero
);
    state_t             r_state;
    logic [31:0]        r_a, r_b, r_y;
    logic               r_sign, r_u_flow, r_o_flow, r_dbz;
    logic signed [9:0]  r_exp;

    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [23:0]        w_ma, w_mb;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic               w_sign, w_ma_lt, w_special, w_spec_dbz, w_start, w_div_done, w_sticky;
    logic [31:0]        w_spec_y;
    logic [24:0]        w_dividend;
    logic signed [9:0]  w_exp_adj, w_exp_fin;
    logic [QUO_BITS-1:0] w_quo;
    logic               w_round_up, w_carry;
    logic [24:0]        w_mant_rnd;
    logic [MAN_W-1:0]   w_frac;

    assign w_ea     = r_a[30:MAN_W];
    assign w_eb     = r_b[30:MAN_W];
    assign w_ma     = {1'b1, r_a[MAN_W-1:0]};
    assign w_mb     = {1'b1, r_b[MAN_W-1:0]};
    assign w_sign   = r_a[SIGN_BIT] ^ r_b[SIGN_BIT];
    assign w_a_nan  = (w_ea == 8'hFF) && (r_a[MAN_W-1:0] != '0);
    assign w_b_nan  = (w_eb == 8'hFF) && (r_b[MAN_W-1:0] != '0);
    assign w_a_inf  = (w_ea == 8'hFF) && (r_a[MAN_W-1:0] == '0);
    assign w_b_inf  = (w_eb == 8'hFF) && (r_b[MAN_W-1:0] == '0);
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);

    // Priority order matters: NaN-producing cases shadow the inf/zero rules.
    always_comb begin
        w_special  = 1'b1;
        w_spec_dbz = 1'b0;
        w_spec_y   = FP_QNAN;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_y = FP_QNAN;
        end else if (w_a_inf) begin
            w_spec_y = {w_sign, FP_INF_MAG};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_y = {w_sign, 31'h0};
        end else if (w_b_zero) begin
            w_spec_y   = {w_sign, FP_INF_MAG};
            w_spec_dbz = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    // Pre-normalise so the quotient always lands in [1,2).
    assign w_ma_lt    = (w_ma < w_mb);
    assign w_dividend = w_ma_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
    assign w_exp_adj  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                        + 10'sd127 - $signed({9'd0, w_ma_lt});
    assign w_start    = (r_state == ST_UNPACK) && !w_special;

    fp_mant_div_seq #(
        .QUO_BITS (QUO_BITS)
    ) u_mant_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_mb),
        .o_done     (w_div_done),
        .o_quotient (w_quo),
        .o_sticky   (w_sticky)
    );

    // w_quo = {integer bit, 23 fraction bits, guard}.
    assign w_round_up = w_quo[0] & (w_sticky | w_quo[1]);
    assign w_mant_rnd = {1'b0, w_quo[QUO_BITS-1:1]} + {24'd0, w_round_up};
    assign w_carry    = w_mant_rnd[24];
    assign w_frac     = w_carry ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
    assign w_exp_fin  = r_exp + $signed({9'd0, w_carry});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_y      <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_u_flow <= 1'b0;
            r_o_flow <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_y     <= w_spec_y;
                        r_dbz   <= w_spec_dbz;
                        r_state <= ST_DONE;
                    end else begin
                        r_exp   <= w_exp_adj;
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (w_exp_fin >= 10'sd255) begin
                        r_y      <= {r_sign, FP_INF_MAG};
                        r_o_flow <= 1'b1;
                    end else if (w_exp_fin <= 10'sd0) begin
                        r_y      <= {r_sign, 31'h0};
                        r_u_flow <= 1'b1;
                    end else begin
                        r_y <= {r_sign, w_exp_fin[EXP_W-1:0], w_frac};
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_u_flow <= 1'b0;
                        r_o_flow <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign y           = r_y;
    assign u_flow      = r_u_flow;
    assign o_flow      = r_o_flow;
    assign div_by_zero = r_dbz;
endmodule : floating_point_spdiv
`default_nettype wire

// File: tb/tb_floating_point_spdiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_floating_point_spdiv                                     |
// | Brief   : Directed self-checking bench for floating_point_spdiv       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_floating_point_spdiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        u_flow, o_flow, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    floating_point_spdiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .u_flow      (u_flow),
        .o_flow      (o_flow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, return result, flags {u,o,dbz} and cycles to out_valid.
    // The result is held for 'hold' extra cycles with out_ready low before release.
    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input int hold,
                         output logic [31:0] y_o, output logic [2:0] f_o, output int lat);
        int guard;
        @(negedge clk);
        a = a_i;
        b = b_i;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        y_o = y;
        f_o = {u_flow, o_flow, div_by_zero};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_y", y, y_o);
            check("hold_flags", {29'd0, u_flow, o_flow, div_by_zero}, {29'd0, f_o});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_flags", {29'd0, u_flow, o_flow, div_by_zero}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] ey;
        logic [2:0]  ef;
        int          elat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] ry;
        logic [2:0]  rf;
        int          rl;
        int          seen;

        vecs[0] = '{"6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27};
        vecs[1] = '{"1div3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 27};
        vecs[2] = '{"divzero", 32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 2};
        vecs[3] = '{"ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b010, 27};
        vecs[4] = '{"unf",     32'h00800000, 32'h40000000, 32'h00000000, 3'b100, 27};
        vecs[5] = '{"nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 2};
        vecs[6] = '{"zdivz",   32'h00000000, 32'h80000000, 32'h7FC00000, 3'b000, 2};
        vecs[7] = '{"m8divinf",32'hC1000000, 32'h7F800000, 32'h80000000, 3'b000, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_flags", {29'd0, u_flow, o_flow, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, 0, ry, rf, rl);
            check({vecs[i].name, "_y"}, ry, vecs[i].ey);
            check({vecs[i].name, "_flags"}, {29'd0, rf}, {29'd0, vecs[i].ef});
            check({vecs[i].name, "_lat"}, rl, vecs[i].elat);
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        do_op(32'h3F800000, 32'h40400000, 10, ry, rf, rl);
        check("bp_y", ry, 32'h3EAAAAAB);

        // Reset in the middle of the divide loop aborts the operation.
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        do_op(32'h40C00000, 32'h40000000, 0, ry, rf, rl);
        check("postrst_y", ry, 32'h40400000);
        check("postrst_lat", rl, 27);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule : tb_floating_point_spdiv
`default_nettype wire
